trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the execute stage and the M-mode CSR file.
- Arbitrates synchronous exceptions, mret and two level-sensitive interrupts, then flushes the pipeline through a req/ack handshake.
- Writes mepc/mcause/mtval one CSR per cycle through a single write port, then issues one PC redirect.
- Owns mstatus.MIE/MPIE.

Parameters:
- XLEN, 32, datapath width.
- MSTATUS_MIE_RST, 0, reset value of mstatus_mie.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- exc_req  in  5  sync exception requests: [0] fetch misalign, [1] ebreak, [2] ecall, [3] store misalign, [4] load misalign
- exc_pc  in  XLEN  pc of the excepting instruction
- exc_tval  in  XLEN  faulting address (misalign), else don't-care
- mret_req  in  1  mret in execute
- irq_pc  in  XLEN  pc of next unretired instruction (interrupt mepc)
- irq_ext  in  1  external interrupt, level
- irq_timer  in  1  timer interrupt, level
- mie_meie  in  1  external interrupt enable (CSR file)
- mie_mtie  in  1  timer interrupt enable (CSR file)
- mtvec  in  XLEN  trap vector (CSR file)
- mepc  in  XLEN  return address (CSR file)
- flush_ack  in  1  pipeline drained
- flush_req  out  1  pipeline flush request
- busy  out  1  state != IDLE; front end stalls
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  0x341 / 0x342 / 0x343
- csr_wdata  out  XLEN  CSR write data
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target
- mstatus_mie  out  1  global interrupt enable
- mstatus_mpie  out  1  previous MIE

Behaviour:
- Reset values: all outputs 0, except mstatus_mie = MSTATUS_MIE_RST and mstatus_mpie = 1; state IDLE.
- FSM states: IDLE, FLUSH, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT.
- Inputs are sampled only in IDLE; requests arriving while busy are ignored.
- Priority, highest first:
  - fetch misalign (cause 0)
  - ebreak (3)
  - ecall (11)
  - store misalign (6)
  - load misalign (4)
  - mret
  - external interrupt (0x8000000B), taken only if mstatus_mie & mie_meie
  - timer interrupt (0x80000007), taken only if mstatus_mie & mie_mtie
- Capture on acceptance (in IDLE) into internal registers:
  - cause
  - epc: exc_pc for exceptions, irq_pc for interrupts
  - tval: exc_tval for cause 4/6; exc_pc for cause 0 and 3; 0 otherwise
  - is_mret flag
- Acceptance in cycle N moves to FLUSH; flush_req=1 from N+1 until flush_ack is sampled high. An ack in the first FLUSH cycle counts. There is no timeout.
- Trap path:
  - Cycle after ack: WR_EPC (csr_we=1, 0x341, epc). In this same cycle mstatus_mpie<=mstatus_mie and mstatus_mie<=0.
  - Then WR_CAUSE (0x342, cause).
  - Then WR_TVAL (0x343, tval).
  - Then REDIRECT: redirect_valid=1, redirect_pc = {mtvec[XLEN-1:2],2'b00}.
  - Then IDLE.
- Mret path:
  - Cycle after ack: REDIRECT with redirect_pc=mepc.
  - In that cycle mstatus_mie<=mstatus_mpie and mstatus_mpie<=1.
  - No CSR writes.
- Latency: acceptance N, ack sampled at M ≥ N+1 → trap redirect at M+4, mret redirect at M+1; IDLE the following cycle.
- csr_we and redirect_valid are mutually exclusive and each is high for exactly the single cycle of its state.
- Simultaneous exception and mret: exception wins and mret is dropped; the pipeline re-issues mret after the flush if needed.
- Interrupt and exception in the same cycle: exception wins; the interrupt, being level-sensitive, is re-evaluated on return to IDLE.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs to reset values, partial CSR writes are not completed.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: for interrupts with mtvec[1:0]==2'b01, redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*cause[4:0]. Exceptions always use the base address.
- Undefined: mtvec[1:0] is ignored and all traps go to the base address.

Test Plan:
- ecall, exc_pc=0x100, mtvec=0x4, flush_ack one cycle after flush_req:
  - writes 0x341=0x100, then 0x342=11, then 0x343=0 on consecutive cycles
  - redirect_pc=0x4
  - mie 1→0, mpie=1
- exc_req=5'b10001 (fetch + load), exc_pc=0x202, exc_tval=0x3003 → cause 0, mtval=0x202; load is dropped.
- mret_req with mepc=0x104, mpie=1, flush_ack held low 5 cycles:
  - flush_req high for 6 cycles
  - redirect_pc=0x104 one cycle after ack; no csr_we; mie=1
- irq_timer=1, mie_mtie=1, mstatus_mie=0 → no action. Set mstatus_mie=1 via mret → mcause=0x80000007, mepc=irq_pc.
- TRAP_VECTORED_EN defined, mtvec=0x1001, irq_ext=1 → redirect_pc=0x102C. Same stimulus with the macro undefined → 0x1000.
- rst_n pulsed low during WR_CAUSE:
  - outputs zero at once, state IDLE
  - a following ebreak sequences normally, cause 3

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap sequencer. It flushes the pipeline, writes mepc/mcause/mtval and redirects the PC.
// Optional macro TRAP_VECTORED_EN: vectored interrupt dispatch when mtvec[1:0] == 2'b01.
module trap_ctrl #(
  parameter int XLEN            = 32,
  parameter bit MSTATUS_MIE_RST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      exc_req,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            mie_meie,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            flush_ack,
  output logic            flush_req,
  output logic            busy,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie,
  output logic            mstatus_mpie
);

  localparam logic [11:0]     ADDR_MEPC   = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE = 12'h342;
  localparam logic [11:0]     ADDR_MTVAL  = 12'h343;
  localparam logic [XLEN-1:0] IRQ_FLAG    = XLEN'(1) << (XLEN - 1);
  localparam logic [XLEN-1:0] CAUSE_MEI   = IRQ_FLAG | XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MTI   = IRQ_FLAG | XLEN'(7);

  typedef enum logic [2:0] {
    IDLE, FLUSH, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT
  } state_t;

  state_t          state;
  logic            is_mret_q;
  logic [XLEN-1:0] cause_q, epc_q, tval_q;

  logic            take, take_mret;
  logic [XLEN-1:0] sel_cause, sel_epc, sel_tval;
  logic [XLEN-1:0] trap_pc;

  // Request arbitration, only acted upon in IDLE.
  always_comb begin
    take      = 1'b1;
    take_mret = 1'b0;
    sel_cause = '0;
    sel_epc   = exc_pc;
    sel_tval  = '0;
    if (exc_req[0]) begin
      sel_cause = XLEN'(0);
      sel_tval  = exc_pc;
    end else if (exc_req[1]) begin
      sel_cause = XLEN'(3);
      sel_tval  = exc_pc;
    end else if (exc_req[2]) begin
      sel_cause = XLEN'(11);
    end else if (exc_req[3]) begin
      sel_cause = XLEN'(6);
      sel_tval  = exc_tval;
    end else if (exc_req[4]) begin
      sel_cause = XLEN'(4);
      sel_tval  = exc_tval;
    end else if (mret_req) begin
      take_mret = 1'b1;
    end else if (irq_ext && mstatus_mie && mie_meie) begin
      sel_cause = CAUSE_MEI;
      sel_epc   = irq_pc;
    end else if (irq_timer && mstatus_mie && mie_mtie) begin
      sel_cause = CAUSE_MTI;
      sel_epc   = irq_pc;
    end else begin
      take = 1'b0;
    end
  end

  always_comb begin
    trap_pc = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (cause_q[XLEN-1] && (mtvec[1:0] == 2'b01))
      trap_pc = trap_pc + XLEN'({cause_q[4:0], 2'b00});
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
`endif

  // Trap payload is plain data and needs no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && take) begin
      cause_q <= sel_cause;
      epc_q   <= sel_epc;
      tval_q  <= sel_tval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      is_mret_q      <= 1'b0;
      flush_req      <= 1'b0;
      busy           <= 1'b0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mstatus_mie    <= MSTATUS_MIE_RST;
      mstatus_mpie   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state     <= FLUSH;
            is_mret_q <= take_mret;
            flush_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            flush_req <= 1'b0;
            if (is_mret_q) begin
              state          <= REDIRECT;
              redirect_valid <= 1'b1;
              redirect_pc    <= mepc;
            end else begin
              state     <= WR_EPC;
              csr_we    <= 1'b1;
              csr_waddr <= ADDR_MEPC;
              csr_wdata <= epc_q;
            end
          end
        end
        WR_EPC: begin
          state        <= WR_CAUSE;
          csr_waddr    <= ADDR_MCAUSE;
          csr_wdata    <= cause_q;
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
        end
        WR_CAUSE: begin
          state     <= WR_TVAL;
          csr_waddr <= ADDR_MTVAL;
          csr_wdata <= tval_q;
        end
        WR_TVAL: begin
          state          <= REDIRECT;
          csr_we         <= 1'b0;
          csr_waddr      <= '0;
          csr_wdata      <= '0;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_pc;
        end
        REDIRECT: begin
          state          <= IDLE;
          busy           <= 1'b0;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          if (is_mret_q) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
